// File: rtl/square_field_pkg.sv
// Shared screen geometry, FSM encoding and LFSR constants for the falling-square renderer.
package square_field_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ERASE = 3'd1,
        MOVE  = 3'd2,
        DRAW  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [2:0] ERASE_COLOR = 3'b000;
    localparam logic [7:0] LFSR_SEED   = 8'hA5;
    // x^8+x^6+x^5+x^4+1 with the register shifting toward bit 7
    localparam logic [7:0] LFSR_TAPS   = 8'b1011_1000;

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << (n % 8);
        return d[15:8];
    endfunction

endpackage

// File: rtl/square_field_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR supplying respawn columns.
module lfsr8
    import square_field_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    output logic [7:0] value
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            value <= LFSR_SEED;
        end else begin
            value <= {value[6:0], ^(value & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/square_field.sv
// Erases, moves and redraws NUM_SQ falling squares, emitting one registered pixel per cycle.
module square_field
    import square_field_pkg::*;
#(
    parameter int         NUM_SQ   = 4,
    parameter int         SQ_SIZE  = 4,
    parameter logic [2:0] SQ_COLOR = 3'b100
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       draw,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] color,
    output logic       plot,
    output logic       finish_drawing,
    output logic       busy
);

    localparam int SQ_W = (NUM_SQ > 1) ? $clog2(NUM_SQ) : 1;
    localparam int D_W  = (SQ_SIZE > 1) ? $clog2(SQ_SIZE) : 1;
    localparam logic [7:0] MAX_X = 8'(SCREEN_W - 1 - SQ_SIZE);
    localparam logic [7:0] MAX_Y = 8'(SCREEN_H - 1 - SQ_SIZE);

    state_t          state, state_nxt;
    logic [SQ_W-1:0] sq, sq_nxt;
    logic [D_W-1:0]  dx, dx_nxt, dy, dy_nxt;
    logic [7:0]      sx [NUM_SQ];
    logic [7:0]      sx_nxt [NUM_SQ];
    logic [6:0]      sy [NUM_SQ];
    logic [6:0]      sy_nxt [NUM_SQ];
    logic            pending;
    logic [7:0]      rnd;
    logic            last_px;
    logic [7:0]      pix_x;
    logic [6:0]      pix_y;
    logic [2:0]      pix_color;
    logic            pix_plot;

    function automatic logic [7:0] step_y(input logic [6:0] cur, input int idx);
        return {1'b0, cur} + ((idx % 2 == 1) ? 8'd2 : 8'd1);
    endfunction

    function automatic logic [7:0] respawn_col(input logic [7:0] v);
        return (v <= MAX_X) ? v : v - 8'd128;
    endfunction

    lfsr8 u_lfsr (
        .clock (clock),
        .reset (reset),
        .value (rnd)
    );

    assign last_px = (sq == SQ_W'(NUM_SQ - 1)) && (dx == D_W'(SQ_SIZE - 1))
                     && (dy == D_W'(SQ_SIZE - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (draw) state_nxt = ERASE;
            ERASE:   if (last_px) state_nxt = MOVE;
            MOVE:    state_nxt = DRAW;
            DRAW:    if (last_px) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Row-major walk over every square; counters return to zero outside ERASE/DRAW.
    always_comb begin
        sq_nxt = '0;
        dx_nxt = '0;
        dy_nxt = '0;
        if ((state == ERASE || state == DRAW) && !last_px) begin
            sq_nxt = sq;
            dy_nxt = dy;
            dx_nxt = dx + 1'b1;
            if (dx == D_W'(SQ_SIZE - 1)) begin
                dx_nxt = '0;
                dy_nxt = dy + 1'b1;
                if (dy == D_W'(SQ_SIZE - 1)) begin
                    dy_nxt = '0;
                    sq_nxt = sq + 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SQ; i++) begin
            sx_nxt[i] = sx[i];
            sy_nxt[i] = sy[i];
            if (state == MOVE && pending) begin
                if (step_y(sy[i], i) > MAX_Y) begin
                    sy_nxt[i] = '0;
                    sx_nxt[i] = respawn_col(rotl8(rnd, 2 * i));
                end else begin
                    sy_nxt[i] = 7'(step_y(sy[i], i));
                end
            end
        end
    end

    // Outputs are derived from next-cycle state so the registered pixel lines up with its state.
    always_comb begin
        pix_plot  = (state_nxt == ERASE) || (state_nxt == DRAW);
        pix_x     = '0;
        pix_y     = '0;
        pix_color = '0;
        if (pix_plot) begin
            pix_x     = sx_nxt[sq_nxt] + 8'(dx_nxt);
            pix_y     = sy_nxt[sq_nxt] + 7'(dy_nxt);
            pix_color = (state_nxt == DRAW) ? SQ_COLOR : ERASE_COLOR;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sq             <= '0;
            dx             <= '0;
            dy             <= '0;
            pending        <= 1'b0;
            x              <= '0;
            y              <= '0;
            color          <= '0;
            plot           <= 1'b0;
            busy           <= 1'b0;
            finish_drawing <= 1'b0;
            for (int i = 0; i < NUM_SQ; i++) begin
                sx[i] <= 8'(16 + 40 * i);
                sy[i] <= 7'(28 * i);
            end
        end else begin
            sq             <= sq_nxt;
            dx             <= dx_nxt;
            dy             <= dy_nxt;
            pending        <= tick || (pending && state != MOVE);
            x              <= pix_x;
            y              <= pix_y;
            color          <= pix_color;
            plot           <= pix_plot;
            busy           <= (state_nxt != IDLE);
            finish_drawing <= (state_nxt == DONE);
            for (int i = 0; i < NUM_SQ; i++) begin
                sx[i] <= sx_nxt[i];
                sy[i] <= sy_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_square_field.sv
// Scoreboard bench for square_field: a behavioural model queues expected pixels per pass.
module tb_square_field;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tick  = 1'b0;
    logic       draw  = 1'b0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] color;
    logic       plot;
    logic       finish_drawing;
    logic       busy;

    square_field #(.NUM_SQ(4), .SQ_SIZE(4), .SQ_COLOR(3'b100)) dut (
        .clock          (clock),
        .reset          (reset),
        .tick           (tick),
        .draw           (draw),
        .x              (x),
        .y              (y),
        .color          (color),
        .plot           (plot),
        .finish_drawing (finish_drawing),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    logic [17:0] exp_q[$];
    logic [17:0] pix_log[128];
    int          pcnt = 0;
    int          finish_cnt = 0;
    int          cyc = 0;
    int          c0 = 0;
    bit          model_idle = 1'b1;
    bit          mpend = 1'b0;
    logic [7:0]  mlfsr;
    logic [7:0]  msx[4];
    logic [6:0]  msy[4];

    always @(posedge clock or negedge reset) begin
        if (!reset) mlfsr <= 8'hA5;
        else        mlfsr <= {mlfsr[6:0], mlfsr[7] ^ mlfsr[5] ^ mlfsr[4] ^ mlfsr[3]};
    end

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void push_pass(input logic [2:0] c);
        for (int i = 0; i < 4; i++)
            for (int dyy = 0; dyy < 4; dyy++)
                for (int dxx = 0; dxx < 4; dxx++)
                    exp_q.push_back({msx[i] + 8'(dxx), msy[i] + 7'(dyy), c});
    endfunction

    function automatic void model_move();
        logic [7:0] ny, r;
        for (int i = 0; i < 4; i++) begin
            ny = {1'b0, msy[i]} + ((i % 2) ? 8'd2 : 8'd1);
            if (ny > 8'd115) begin
                r = mlfsr;
                for (int k = 0; k < 2 * i; k++) r = {r[6:0], r[7]};
                msx[i] = (r <= 8'd155) ? r : r - 8'd128;
                msy[i] = 7'd0;
            end else begin
                msy[i] = ny[6:0];
            end
        end
    endfunction

    always @(negedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                msx[i] = 8'(16 + 40 * i);
                msy[i] = 7'(28 * i);
            end
            mpend = 1'b0;
            model_idle = 1'b1;
            pcnt = 0;
            exp_q.delete();
        end else begin
            if (model_idle && draw) begin
                model_idle = 1'b0;
                pcnt = 0;
                c0 = cyc;
                push_pass(3'b000);
            end
            if (plot) begin
                if (exp_q.size() == 0) check("plot_outside_pass", 32'(plot), 32'd0);
                else check("pixel", 32'({x, y, color}), 32'(exp_q.pop_front()));
                if (pcnt < 128) pix_log[pcnt] = {x, y, color};
                pcnt++;
            end
            if (finish_drawing) begin
                finish_cnt++;
                check("plot_count", pcnt, 128);
                check("finish_cycle", cyc - c0, 130);
                check("queue_left", exp_q.size(), 0);
                model_idle = 1'b1;
            end else if (busy && !plot) begin
                if (mpend) model_move();
                mpend = 1'b0;
                push_pass(3'b100);
            end
            if (tick) mpend = 1'b1;
        end
    end

    task automatic wait_finish(input int budget);
        int f0 = finish_cnt;
        int n = 0;
        while (finish_cnt == f0 && n < budget) begin
            @(negedge clock);
            #1;
            n++;
        end
        check("finish_seen", finish_cnt - f0, 1);
    endtask

    task automatic pulse_draw();
        @(posedge clock); #1 draw = 1'b1;
        @(posedge clock); #1 draw = 1'b0;
    endtask

    task automatic pulse_tick();
        @(posedge clock); #1 tick = 1'b1;
        @(posedge clock); #1 tick = 1'b0;
    endtask

    task automatic run_pass();
        pulse_draw();
        wait_finish(300);
    endtask

    task automatic do_reset();
        @(posedge clock); #1 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    initial begin
        int f0;
        int n;
        #3 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_x", 32'(x), 0);
        check("rst_y", 32'(y), 0);
        check("rst_color", 32'(color), 0);
        check("rst_plot", 32'(plot), 0);
        check("rst_finish", 32'(finish_drawing), 0);
        check("rst_busy", 32'(busy), 0);
        reset = 1'b1;

        run_pass();
        check("first_pixel", 32'(pix_log[0]), 32'({8'd16, 7'd0, 3'b000}));
        check("pixel65", 32'(pix_log[64]), 32'({8'd16, 7'd0, 3'b100}));

        pulse_tick();
        run_pass();
        check("sq0_after_tick", 32'(pix_log[64]), 32'({8'd16, 7'd1, 3'b100}));
        check("sq1_after_tick", 32'(pix_log[80]), 32'({8'd56, 7'd30, 3'b100}));

        f0 = finish_cnt;
        @(posedge clock); #1 draw = 1'b1;
        wait_finish(300);
        @(posedge clock); #1 draw = 1'b0;
        repeat (200) @(posedge clock);
        #1 check("held_draw_one_pass", finish_cnt - f0, 1);

        do_reset();
        pulse_tick();
        @(posedge clock); #1 draw = 1'b1;
        @(posedge clock); #1 draw = 1'b0;
        repeat (64) @(posedge clock);
        #1 tick = 1'b1;
        @(posedge clock); #1 tick = 1'b0;
        wait_finish(300);
        check("move_tick_pass1", 32'(pix_log[64]), 32'({8'd16, 7'd1, 3'b100}));
        run_pass();
        check("move_tick_pass2", 32'(pix_log[64]), 32'({8'd16, 7'd2, 3'b100}));
        run_pass();
        check("flag_cleared", 32'(pix_log[64]), 32'({8'd16, 7'd2, 3'b100}));

        do_reset();
        for (int p = 0; p < 15; p++) begin
            pulse_tick();
            run_pass();
        end
        check("sq3_y114", 32'(pix_log[112][9:3]), 114);
        pulse_tick();
        run_pass();
        check("sq3_respawn_y", 32'(pix_log[112][9:3]), 0);
        check("sq3_respawn_range", 32'(pix_log[112][17:10] <= 8'd155), 1);
        check("sq3_respawn_x", 32'(pix_log[112][17:10]), 32'(msx[3]));

        do_reset();
        @(posedge clock); #1 draw = 1'b1;
        @(posedge clock); #1 draw = 1'b0;
        n = 0;
        while (pcnt < 40 && n < 100) begin
            @(negedge clock);
            #1;
            n++;
        end
        check("reached_plot40", pcnt, 40);
        f0 = finish_cnt;
        reset = 1'b0;
        #1;
        check("abort_plot", 32'(plot), 0);
        check("abort_busy", 32'(busy), 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        repeat (200) @(posedge clock);
        #1 check("abort_no_finish", finish_cnt - f0, 0);
        run_pass();
        check("restart_pixel", 32'(pix_log[0]), 32'({8'd16, 7'd0, 3'b000}));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/square_field.md
SQUARE_FIELD -- requirements
Module: square_field

Interface
REQ-001 Parameter NUM_SQ, default 4: number of falling squares.
REQ-002 Parameter SQ_SIZE, default 4: square edge in pixels.
REQ-003 Parameter SQ_COLOR, default 3'b100: colour used to draw a square.
REQ-004 Port clock, input, 1: single system clock; all state on posedge clock.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port tick, input, 1: one-cycle frame-advance pulse from the delay counter.
REQ-007 Port draw, input, 1: one-cycle render request from the control FSM.
REQ-008 Port x, output, 8: pixel column for the VGA select stage.
REQ-009 Port y, output, 7: pixel row for the VGA select stage.
REQ-010 Port color, output, 3: pixel colour.
REQ-011 Port plot, output, 1: the x/y/color outputs are a valid pixel this cycle.
REQ-012 Port finish_drawing, output, 1: one-cycle pulse when a render pass completes.
REQ-013 Port busy, output, 1: high from the cycle after accepted draw through the finish_drawing cycle.

Function
REQ-014 The FSM states SHALL be IDLE, ERASE, MOVE, DRAW and DONE.
REQ-015 State transitions:
- IDLE to ERASE on draw.
- ERASE to MOVE after the last pixel.
- MOVE to DRAW after exactly 1 cycle.
- DRAW to DONE after the last pixel.
- DONE to IDLE after exactly 1 cycle.
REQ-016 draw SHALL be ignored in every state except IDLE.
REQ-017 ERASE and DRAW SHALL each walk squares 0..NUM_SQ-1 in order.
- Each square is walked row-major, SQ_SIZE*SQ_SIZE pixels, one pixel per cycle with plot=1.
- Pixel (dx,dy) is at x=sx+dx, y=sy+dy.
REQ-018 ERASE colour SHALL be 3'b000; DRAW colour SHALL be SQ_COLOR.
REQ-019 Total plot cycles per pass SHALL be 2*NUM_SQ*SQ_SIZE^2 (128 at defaults); plot SHALL be 0 in IDLE, MOVE and DONE.
REQ-020 The first plotted pixel SHALL appear in the cycle after draw is sampled; finish_drawing SHALL pulse in DONE.
REQ-021 tick SHALL set a pending flag in any state; MOVE SHALL clear the flag.
- Positions change only in MOVE with the flag set.
- A tick arriving in the same cycle as MOVE SHALL remain pending.
REQ-022 Fall speed SHALL be 1 px per move for even-index squares and 2 px for odd-index squares.
REQ-023 In MOVE, ny = sy + speed is computed at 8 bits.
- If ny > 119-SQ_SIZE, the square respawns with sy=0 and sx taken from the LFSR.
- Otherwise sy = ny.
REQ-024 Respawn column SHALL be v if v <= 159-SQ_SIZE, else v-128, where v is the current LFSR value.
- Multiple squares respawning in one MOVE SHALL take LFSR bits rotated by 2*i for square i.
REQ-025 The LFSR SHALL be 8 bits, polynomial x^8+x^6+x^5+x^4+1, seeded 8'hA5, advancing every cycle.
REQ-026 x, y and color SHALL be registered outputs.

Reset
REQ-027 On reset low, the following SHALL clear immediately: state=IDLE, plot=0, finish_drawing=0, busy=0, x=0, y=0, color=0, tick flag=0, LFSR=8'hA5.
REQ-028 Reset positions: square i SHALL be at sx=16+40*i, sy=28*i (defaults: (16,0),(56,28),(96,56),(136,84)).
REQ-029 Reset mid-pass SHALL abort the pass with no finish_drawing pulse.

Structure
REQ-030 A shared package SHALL hold SCREEN_W=160, SCREEN_H=120, the state encoding, ERASE_COLOR and the LFSR seed and taps.
REQ-031 The LFSR SHALL be a sub-module, lfsr8, with ports clock, reset and value[7:0].

Verification
REQ-032 Reset, then draw with no tick:
- 128 plot cycles result.
- First pixel is (16,0) colour 000.
- Pixel 65 is (16,0) colour 100.
- finish_drawing pulses at cycle 130; positions are unchanged.
REQ-033 tick then draw -> in DRAW, square0 is at (16,1) and square1 at (56,30).
REQ-034 draw asserted every cycle during a pass -> exactly one pass runs and exactly one finish_drawing pulse occurs.
REQ-035 Square3 (speed 2) is stepped from sy=114 -> sy becomes 0 and sx equals the rule in REQ-024, which is <=155.
REQ-036 Reset pulsed at plot cycle 40 -> plot=0 asynchronously, no finish_drawing, and a new draw restarts at (16,0).
REQ-037 tick coincident with the MOVE cycle -> the flag stays set and the next pass moves again.
